ifetch_rom_arbiter: RTL and testbench
=====================================

Name: ifetch_rom_arbiter

Overview:
- Owns the single read port of the combinational instruction ROM.
- Arbitrates that port between the pipeline's sequential instruction-fetch stream and a secondary word-read port, used by the debug/constant-table path.
- Fetched words are buffered in a small prefetch FIFO that decouples the ROM from the decode-stage handshake.
- Branch/jump redirects from the pipeline flush the FIFO and restart fetch at the new PC.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h00000000, fetch PC loaded on reset

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- rom_addr  output  32  byte address to ROM (ROM decodes addr[7:2])
- rom_data  input  32  ROM read data, combinational from rom_addr, same cycle
- redirect_valid  input  1  pipeline redirect (taken branch/jump/jr)
- redirect_pc  input  32  redirect target
- inst_valid  output  1  FIFO head valid toward decode
- inst  output  32  FIFO head instruction word
- inst_pc  output  32  FIFO head PC
- inst_ready  input  1  decode accepts head this cycle
- dbg_req  input  1  secondary read request, held until dbg_ack
- dbg_addr  input  32  secondary read byte address
- dbg_ack  output  1  one-cycle pulse, dbg_data valid
- dbg_data  output  32  registered read data

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC; FIFO count=0; head/tail pointers=0.
  - last_grant=FETCH; dbg_ack=0; dbg_data=0.
  - inst_valid=0. rom_addr follows fetch_pc (=RESET_PC).
- Request terms:
  - fetch_req = (count<DEPTH) && !redirect_valid. No credit is taken for a same-cycle pop.
  - dbg_elig = dbg_req && !dbg_ack. A requester is never re-granted in its own ack cycle.
- Grant, one per cycle:
  - Only one requester → it wins.
  - Both request → grant goes to the one not in last_grant; last_grant updates on every grant. The first contended grant after reset goes to DBG.
- rom_addr:
  - DBG grant → dbg_addr.
  - Otherwise → fetch_pc, including idle cycles.
- FETCH grant:
  - Push {fetch_pc, rom_data} at the tail.
  - fetch_pc += 4, 32-bit wrap with no flag.
- DBG grant:
  - Next edge: dbg_data ← rom_data, dbg_ack ← 1.
  - dbg_ack is 0 in every other cycle.
  - Latency is exactly 1 cycle from grant.
- Output handshake:
  - inst_valid = (count!=0) && !redirect_valid.
  - inst and inst_pc = FIFO head.
  - Pop when inst_valid && inst_ready.
- Count update:
  - Push and pop in the same cycle → count unchanged.
  - A push at count==DEPTH cannot occur, because fetch_req is low.
- Redirect cycle:
  - No pop and no push.
  - At the edge: count=0, pointers=0, fetch_pc = {redirect_pc[31:2],2'b00}.
  - Earliest next inst_valid is 2 cycles after the redirect cycle: the fetch grant happens in cycle N+1 and the entry is valid in N+2.
  - A DBG grant in the redirect cycle proceeds normally.
  - last_grant is unchanged unless DBG is granted.
- Redirect while dbg grant is outstanding: the dbg_ack/dbg_data delivery is unaffected.
- Reset mid-operation (in-flight dbg grant, full FIFO): everything clears immediately; no dbg_ack is issued afterward.
- Back-to-back redirects: the last one wins; the FIFO stays empty.
- Sustained throughput, no dbg traffic, decode always ready: one instruction per cycle after the initial 1-cycle fill.

Test Plan:
- Reset fetch: release reset, inst_ready=1, ROM loaded with the sum test program →
  - inst_valid rises the cycle after the first edge.
  - inst_pc=0x0, inst=0x20040003.
  - Next cycle: inst_pc=0x4, inst=0x0C000003.
  - PCs then step by 4.
- FIFO full: inst_ready=0 from reset →
  - count reaches 4 after 4 fetch grants; fetch_pc holds 0x10; no further pushes.
  - Raise inst_ready: pops PCs 0x0,0x4,0x8,0xC in order; fetching resumes the cycle after the first pop.
- Redirect: with the FIFO holding 3 entries, pulse redirect_valid with redirect_pc=0x0E →
  - inst_valid=0 in the redirect cycle and the next.
  - Then inst_pc=0x0C, inst=0x23BDFFF8, followed by 0x10.
- Arbitration: dbg_req held high with dbg_addr=0x08, FIFO not full →
  - First grant goes to DBG.
  - dbg_ack pulses the next cycle with dbg_data=0x1000FFFF.
  - The ack cycle grants FETCH; grants alternate while both request.
- Simultaneous push/pop at count=DEPTH-1 with inst_ready=1 → count stays 3 and FIFO order is preserved.
- Async reset asserted mid-run: at the same moment as an in-flight DBG grant and a full FIFO →
  - inst_valid=0 and dbg_ack=0 immediately; no ack is ever produced.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_rom_arbiter_if.sv
// Signal bundle between the instruction ROM arbiter, the ROM, the decode stage and the debug read port.
// The slave modport is the arbiter's view of the bundle; the master modport is the view from everything around it.
interface ifetch_rom_arbiter_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  modport slave (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready,
    input  dbg_req,
    input  dbg_addr,
    output dbg_ack,
    output dbg_data
  );

  modport master (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready,
    output dbg_req,
    output dbg_addr,
    input  dbg_ack,
    input  dbg_data
  );
endinterface

// File: rtl/ifetch_rom_arbiter.sv
// Shares the single combinational instruction-ROM read port between sequential fetch and a debug word-read port.
// Fetched words go into a small prefetch FIFO; a redirect flushes the FIFO and restarts fetch at the new PC.
module ifetch_rom_arbiter #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  clk,
  input logic                  reset,
  ifetch_rom_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DBG   = 1'b1
  } grant_e;

  grant_e        r_last_grant;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic          r_dbg_ack;
  logic [31:0]   r_dbg_data;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];

  logic w_fetch_req;
  logic w_dbg_elig;
  logic w_gnt_dbg;
  logic w_gnt_fetch;
  logic w_pop;
  logic w_unused;

  // No credit is taken for a same-cycle pop, so a full FIFO always skips one fetch slot.
  assign w_fetch_req = (r_count < CW'(DEPTH)) && !bus.redirect_valid;
  assign w_dbg_elig  = bus.dbg_req && !r_dbg_ack;
  assign w_gnt_dbg   = w_dbg_elig && (!w_fetch_req || (r_last_grant == GNT_FETCH));
  assign w_gnt_fetch = w_fetch_req && !w_gnt_dbg;

  assign bus.rom_addr   = w_gnt_dbg ? bus.dbg_addr : r_fetch_pc;
  assign bus.inst_valid = (r_count != '0) && !bus.redirect_valid;
  assign bus.inst       = r_mem_inst[r_head];
  assign bus.inst_pc    = r_mem_pc[r_head];
  assign bus.dbg_ack    = r_dbg_ack;
  assign bus.dbg_data   = r_dbg_data;

  assign w_pop    = bus.inst_valid && bus.inst_ready;
  assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GNT_FETCH;
      r_fetch_pc   <= RESET_PC;
      r_count      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_dbg_ack    <= 1'b0;
      r_dbg_data   <= '0;
    end else begin
      if (w_gnt_dbg) begin
        r_dbg_ack    <= 1'b1;
        r_dbg_data   <= bus.rom_data;
        r_last_grant <= GNT_DBG;
      end else begin
        r_dbg_ack <= 1'b0;
      end

      if (bus.redirect_valid) begin
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      end else begin
        if (w_gnt_fetch) begin
          r_tail       <= r_tail + AW'(1);
          r_fetch_pc   <= r_fetch_pc + 32'd4;
          r_last_grant <= GNT_FETCH;
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        case ({w_gnt_fetch, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry payload needs no reset: r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_gnt_fetch) begin
      r_mem_pc[r_tail]   <= r_fetch_pc;
      r_mem_inst[r_tail] <= bus.rom_data;
    end
  end
endmodule

// File: tb/tb_ifetch_rom_arbiter.sv
// Self-checking bench for ifetch_rom_arbiter: a behavioural ROM, a scoreboard for the decode stream,
// and cycle-exact checks of arbitration, redirect and reset behaviour.
module tb_ifetch_rom_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ifetch_rom_arbiter_if bus();

  logic [31:0] rom_mem [64];
  assign bus.rom_data = rom_mem[bus.rom_addr[7:2]];

  ifetch_rom_arbiter #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_e;
  logic [31:0] exp_dbg;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected decode stream after a reset or redirect: consecutive words from pc onward.
  task automatic sb_restart(input logic [31:0] pc);
    logic [31:0] p;
    exp_q.delete();
    for (int k = 0; k < 48; k++) begin
      p = pc + 32'(4 * k);
      exp_q.push_back({p, rom_mem[p[7:2]]});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_val("sb_pc", bus.inst_pc, exp_e[63:32]);
        check_val("sb_inst", bus.inst, exp_e[31:0]);
      end
    end
    if (reset === 1'b1 && bus.dbg_ack) begin
      check_val("sb_dbg_data", bus.dbg_data, exp_dbg);
    end
  end

  initial begin
    rom_mem[0] = 32'h2004_0003;
    rom_mem[1] = 32'h0C00_0003;
    rom_mem[2] = 32'h1000_FFFF;
    rom_mem[3] = 32'h23BD_FFF8;
    for (int i = 4; i < 64; i++) rom_mem[i] = 32'hC0DE_0000 | 32'(i);

    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    bus.dbg_req        = 1'b0;
    bus.dbg_addr       = '0;
    exp_dbg            = '0;

    // Reset state
    cyc();
    @(negedge clk);
    check_val("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check_val("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
    check_val("rst_dbg_data", bus.dbg_data, 32'd0);
    check_val("rst_rom_addr", bus.rom_addr, 32'h0);

    // Fetch from reset, decode always ready
    cyc();
    reset = 1'b1;
    bus.inst_ready = 1'b1;
    sb_restart(32'h0);
    @(negedge clk);
    check_val("t1_first_cycle_valid", 32'(bus.inst_valid), 32'd0);
    check_val("t1_first_rom_addr", bus.rom_addr, 32'h0);
    cyc();
    @(negedge clk);
    check_val("t1_valid", 32'(bus.inst_valid), 32'd1);
    check_val("t1_pc0", bus.inst_pc, 32'h0);
    check_val("t1_inst0", bus.inst, 32'h2004_0003);
    cyc();
    @(negedge clk);
    check_val("t1_pc4", bus.inst_pc, 32'h4);
    check_val("t1_inst4", bus.inst, 32'h0C00_0003);
    for (int i = 0; i < 8; i++) begin
      cyc();
      @(negedge clk);
      check_val("t1_stream_valid", 32'(bus.inst_valid), 32'd1);
      check_val("t1_stream_pc", bus.inst_pc, 32'(8 + 4 * i));
    end

    // FIFO fills with decode stalled, then drains in order
    cyc();
    reset = 1'b0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    check_val("t2_async_clear_valid", 32'(bus.inst_valid), 32'd0);
    cyc();
    reset = 1'b1;
    sb_restart(32'h0);
    repeat (4) cyc();
    @(negedge clk);
    check_val("t2_full_rom_addr", bus.rom_addr, 32'h10);
    check_val("t2_full_head_pc", bus.inst_pc, 32'h0);
    cyc();
    cyc();
    @(negedge clk);
    check_val("t2_full_hold_addr", bus.rom_addr, 32'h10);
    cyc();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check_val("t2_pop0_pc", bus.inst_pc, 32'h0);
    check_val("t2_no_fetch_when_full", bus.rom_addr, 32'h10);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      @(negedge clk);
      check_val("t2_drain_pc", bus.inst_pc, 32'(4 * i));
      check_val("t2_occupancy3", bus.rom_addr - bus.inst_pc, 32'd12);
    end

    // Redirect with three entries buffered
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_000E;
    sb_restart(32'h0C);
    @(negedge clk);
    check_val("t3_redirect_valid", 32'(bus.inst_valid), 32'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check_val("t3_after_valid", 32'(bus.inst_valid), 32'd0);
    check_val("t3_refetch_addr", bus.rom_addr, 32'h0C);
    cyc();
    @(negedge clk);
    check_val("t3_target_valid", 32'(bus.inst_valid), 32'd1);
    check_val("t3_target_pc", bus.inst_pc, 32'h0C);
    check_val("t3_target_inst", bus.inst, 32'h23BD_FFF8);
    cyc();
    @(negedge clk);
    check_val("t3_next_pc", bus.inst_pc, 32'h10);

    // Back-to-back redirects: last one wins
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    sb_restart(32'h40);
    @(negedge clk);
    check_val("t3b_valid_r1", 32'(bus.inst_valid), 32'd0);
    cyc();
    bus.redirect_pc = 32'h26;
    sb_restart(32'h24);
    @(negedge clk);
    check_val("t3b_valid_r2", 32'(bus.inst_valid), 32'd0);
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check_val("t3b_valid_gap", 32'(bus.inst_valid), 32'd0);
    check_val("t3b_fetch_addr", bus.rom_addr, 32'h24);
    cyc();
    @(negedge clk);
    check_val("t3b_pc", bus.inst_pc, 32'h24);

    // Arbitration: debug requests continuously against fetch
    cyc();
    reset = 1'b0;
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h08;
    exp_dbg = 32'h1000_FFFF;
    cyc();
    reset = 1'b1;
    sb_restart(32'h0);
    @(negedge clk);
    check_val("t4_first_grant_dbg", bus.rom_addr, 32'h08);
    check_val("t4_no_ack_yet", 32'(bus.dbg_ack), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      if (k % 2 == 0) begin
        check_val("t4_ack", 32'(bus.dbg_ack), 32'd1);
        check_val("t4_ack_data", bus.dbg_data, 32'h1000_FFFF);
        check_val("t4_fetch_grant", bus.rom_addr, 32'(4 * (k / 2)));
      end else begin
        check_val("t4_ack_low", 32'(bus.dbg_ack), 32'd0);
        check_val("t4_dbg_grant", bus.rom_addr, 32'h08);
      end
    end
    cyc();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check_val("t4_last_ack", 32'(bus.dbg_ack), 32'd1);

    // Debug read during a redirect with the FIFO full
    bus.inst_ready = 1'b0;
    repeat (6) cyc();
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h0C;
    exp_dbg = 32'h23BD_FFF8;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h30;
    sb_restart(32'h30);
    @(negedge clk);
    check_val("t5_dbg_in_redirect", bus.rom_addr, 32'h0C);
    cyc();
    bus.redirect_valid = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check_val("t5_ack", 32'(bus.dbg_ack), 32'd1);
    check_val("t5_data", bus.dbg_data, 32'h23BD_FFF8);
    check_val("t5_refetch", bus.rom_addr, 32'h30);
    cyc();
    @(negedge clk);
    check_val("t5_ack_pulse", 32'(bus.dbg_ack), 32'd0);
    check_val("t5_head_pc", bus.inst_pc, 32'h30);

    // Async reset with a full FIFO and a debug grant in flight
    repeat (5) cyc();
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h08;
    exp_dbg = 32'h1000_FFFF;
    #1;
    check_val("t6_inflight", bus.rom_addr, 32'h08);
    check_val("t6_full_valid", 32'(bus.inst_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_val("t6_valid_clr", 32'(bus.inst_valid), 32'd0);
    check_val("t6_ack_clr", 32'(bus.dbg_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.dbg_req = 1'b0;
      @(negedge clk);
      check_val("t6_no_ack", 32'(bus.dbg_ack), 32'd0);
    end
    cyc();
    reset = 1'b1;
    bus.inst_ready = 1'b1;
    sb_restart(32'h0);
    @(negedge clk);
    check_val("t6_restart_addr", bus.rom_addr, 32'h0);
    check_val("t6_restart_ack", 32'(bus.dbg_ack), 32'd0);
    cyc();
    @(negedge clk);
    check_val("t6_restart_pc", bus.inst_pc, 32'h0);
    check_val("t6_restart_inst", bus.inst, 32'h2004_0003);
    repeat (4) cyc();
    @(negedge clk);
    check_val("t6_stream_valid", 32'(bus.inst_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
